ifu_fetch: RTL and testbench

- Instruction fetch unit; sits directly downstream of the program-counter register.
- Samples the current pc after reset and after every pc update, and issues a single-beat read on the instruction memory port.
- Returns the fetched word, with its pc and a fault indication, to the decode stage through a valid/ready handshake.
- One outstanding request at a time, matching the multi-cycle core.

---
 rtl/ifu_fetch.sv | 189 ++++++++++++++++++
 tb/tb_ifu_fetch.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: samples the pc after reset or a pc update, issues one
// read on the instruction memory port and hands the word (or a fault) to decode.
module ifu_fetch #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc,
  input  logic             pc_update,
  output logic             arvalid,
  input  logic             arready,
  output logic [WIDTH-1:0] araddr,
  input  logic             rvalid,
  output logic             rready,
  input  logic [31:0]      rdata,
  input  logic [1:0]       rresp,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [31:0]      inst,
  output logic [WIDTH-1:0] inst_pc,
  output logic             fault,
  output logic [1:0]       fault_cause,
  output logic             busy
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam bit WDOG_EN = (TIMEOUT != 0);

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_MISALGN = 2'b01;
  localparam logic [1:0] CAUSE_ACCESS  = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  state_t           state_r;
  logic             pending_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] araddr_r;
  logic [31:0]      inst_r;
  logic [WIDTH-1:0] inst_pc_r;
  logic             fault_r;
  logic [1:0]       cause_r;
  logic             leave_idle_s;

  function automatic logic word_aligned(input logic [WIDTH-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

  assign leave_idle_s = (state_r == ST_IDLE) && pending_r;

  // Fetch FSM, pending-update flag, watchdog and captured result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      pending_r <= 1'b1;
      cnt_r     <= {CNT_W{1'b0}};
      araddr_r  <= {WIDTH{1'b0}};
      inst_r    <= 32'h0000_0000;
      inst_pc_r <= {WIDTH{1'b0}};
      fault_r   <= 1'b0;
      cause_r   <= CAUSE_NONE;
    end else begin
      // An update arriving on the same edge that leaves IDLE wins, so it is fetched next.
      if (pc_update) begin
        pending_r <= 1'b1;
      end else if (leave_idle_s) begin
        pending_r <= 1'b0;
      end else begin
        pending_r <= pending_r;
      end

      case (state_r)
        ST_IDLE: begin
          if (pending_r) begin
            inst_pc_r <= pc;
            if (word_aligned(pc)) begin
              araddr_r <= pc;
              state_r  <= ST_REQ;
            end else begin
              inst_r  <= 32'h0000_0000;
              fault_r <= 1'b1;
              cause_r <= CAUSE_MISALGN;
              state_r <= ST_OUT;
            end
          end
        end
        ST_REQ: begin
          if (arready) begin
            cnt_r   <= {CNT_W{1'b0}};
            state_r <= ST_RESP;
          end
        end
        ST_RESP: begin
          // Data arriving on the expiry cycle is still taken.
          if (rvalid) begin
            inst_r  <= rdata;
            fault_r <= (rresp != 2'b00);
            cause_r <= (rresp != 2'b00) ? CAUSE_ACCESS : CAUSE_NONE;
            state_r <= ST_OUT;
          end else if (WDOG_EN && (cnt_r == CNT_LAST)) begin
            inst_r  <= 32'h0000_0000;
            fault_r <= 1'b1;
            cause_r <= CAUSE_TIMEOUT;
            state_r <= ST_OUT;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_OUT: begin
          if (inst_ready) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign arvalid     = (state_r == ST_REQ);
  assign rready      = (state_r == ST_RESP);
  assign inst_valid  = (state_r == ST_OUT);
  assign araddr      = araddr_r;
  assign inst        = inst_r;
  assign inst_pc     = inst_pc_r;
  assign fault       = fault_r;
  assign fault_cause = cause_r;
  assign busy        = (state_r != ST_IDLE) || pending_r;

  ifu_fetch_chk #(.WIDTH(WIDTH)) u_chk (
    .clk         (clk),
    .rst         (rst),
    .arvalid     (arvalid),
    .arready     (arready),
    .araddr      (araddr),
    .rready      (rready),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .fault       (fault),
    .fault_cause (fault_cause)
  );

endmodule

// Protocol checker: request and result stability, alignment, state exclusivity.
module ifu_fetch_chk #(
  parameter int WIDTH = 32
) (
  input logic             clk,
  input logic             rst,
  input logic             arvalid,
  input logic             arready,
  input logic [WIDTH-1:0] araddr,
  input logic             rready,
  input logic             inst_valid,
  input logic             inst_ready,
  input logic [31:0]      inst,
  input logic [WIDTH-1:0] inst_pc,
  input logic             fault,
  input logic [1:0]       fault_cause
);

  ar_hold_a: assert property (@(posedge clk) disable iff (!rst)
    (arvalid && !arready) |=> (arvalid && $stable(araddr)));

  ar_align_a: assert property (@(posedge clk) disable iff (!rst)
    arvalid |-> (araddr[1:0] == 2'b00));

  out_hold_a: assert property (@(posedge clk) disable iff (!rst)
    (inst_valid && !inst_ready) |=> (inst_valid && $stable({inst, inst_pc, fault, fault_cause})));

  one_state_a: assert property (@(posedge clk) disable iff (!rst)
    $onehot0({arvalid, rready, inst_valid}));

  fault_code_a: assert property (@(posedge clk) disable iff (!rst)
    inst_valid |-> (fault == (fault_cause != 2'b00)));

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch with a result scoreboard and a small memory driver.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        pc_update;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        fault;
  logic [1:0]  fault_cause;
  logic        busy;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
    logic [1:0]  cause;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   ar_count = 0;
  int   n_resp;

  always #5 clk = ~clk;

  ifu_fetch #(.WIDTH(32), .TIMEOUT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .pc_update   (pc_update),
    .arvalid     (arvalid),
    .arready     (arready),
    .araddr      (araddr),
    .rvalid      (rvalid),
    .rready      (rready),
    .rdata       (rdata),
    .rresp       (rresp),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .fault       (fault),
    .fault_cause (fault_cause),
    .busy        (busy)
  );

  always @(posedge clk) begin
    if (arvalid && arready) ar_count <= ar_count + 1;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // which: 0 = arvalid, 1 = rready, other = inst_valid; returns on a negedge
  task automatic wait_for(input int which, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      case (which)
        0:       seen = arvalid;
        1:       seen = rready;
        default: seen = inst_valid;
      endcase
    end
    check({tag, "_wait"}, 128'(seen), 128'(1'b1));
  endtask

  task automatic pc_step(input logic [31:0] new_pc);
    pc_update = 1'b1;
    @(posedge clk);
    #1;
    pc        = new_pc;
    pc_update = 1'b0;
  endtask

  task automatic out_check(input string tag);
    exp_t e;
    check({tag, "_sb"}, 128'(sb.size() != 0), 128'(1'b1));
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_inst"},  128'(inst),        128'(e.inst));
      check({tag, "_pc"},    128'(inst_pc),     128'(e.pc));
      check({tag, "_fault"}, 128'(fault),       128'(e.fault));
      check({tag, "_cause"}, 128'(fault_cause), 128'(e.cause));
    end
  endtask

  task automatic do_fetch(input logic [31:0] addr, input int ar_stall, input int r_delay,
                          input logic [31:0] data, input logic [1:0] resp,
                          input int ir_stall, input string tag);
    exp_t e;
    e.inst  = data;
    e.pc    = addr;
    e.fault = (resp != 2'b00);
    e.cause = (resp != 2'b00) ? 2'b10 : 2'b00;
    sb.push_back(e);
    arready    = (ar_stall == 0);
    inst_ready = (ir_stall == 0);
    wait_for(0, {tag, "_ar"});
    check({tag, "_araddr"}, 128'(araddr), 128'(addr));
    for (int k = 0; k < ar_stall; k++) begin
      @(negedge clk);
      check({tag, "_ar_hold"}, 128'({arvalid, araddr}), 128'({1'b1, addr}));
    end
    arready = 1'b1;
    wait_for(1, {tag, "_r"});
    arready = 1'b0;
    for (int k = 0; k < r_delay; k++) @(negedge clk);
    rvalid = 1'b1;
    rdata  = data;
    rresp  = resp;
    wait_for(2, {tag, "_out"});
    rvalid = 1'b0;
    rdata  = 32'h0;
    rresp  = 2'b00;
    for (int k = 0; k < ir_stall; k++) begin
      @(negedge clk);
      check({tag, "_out_hold"}, 128'({inst_valid, inst, inst_pc}), 128'({1'b1, data, addr}));
    end
    inst_ready = 1'b1;
    out_check(tag);
    @(negedge clk);
    check({tag, "_drop"}, 128'({inst_valid, inst}), 128'({1'b0, data}));
    inst_ready = 1'b0;
  endtask

  initial begin
    exp_t e;
    rst        = 1'b0;
    pc         = 32'h8000_0000;
    pc_update  = 1'b0;
    arready    = 1'b0;
    rvalid     = 1'b0;
    rdata      = 32'h0;
    rresp      = 2'b00;
    inst_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_outs",
          128'({arvalid, rready, inst_valid, fault, fault_cause, araddr, inst, inst_pc}),
          128'(0));
    rst = 1'b1;

    // Fetch right after reset release, zero-wait memory, decode always ready.
    do_fetch(32'h8000_0000, 0, 0, 32'h0000_0413, 2'b00, 0, "basic");
    check("basic_ar_count", 128'(ar_count), 128'(1));
    check("basic_idle", 128'({busy, inst_valid}), 128'(0));

    // Backpressure on both the request and the result.
    pc_step(32'h8000_0004);
    do_fetch(32'h8000_0004, 3, 1, 32'h0010_0093, 2'b00, 4, "bp");
    check("bp_ar_count", 128'(ar_count), 128'(2));

    // Misaligned pc: fault without a memory request.
    pc_step(32'h8000_0002);
    e = '{inst: 32'h0, pc: 32'h8000_0002, fault: 1'b1, cause: 2'b01};
    sb.push_back(e);
    wait_for(2, "mis_out");
    check("mis_no_ar", 128'({arvalid, 32'(ar_count)}), 128'({1'b0, 32'd2}));
    inst_ready = 1'b1;
    out_check("mis");
    @(negedge clk);
    check("mis_drop", 128'(inst_valid), 128'(1'b0));
    inst_ready = 1'b0;

    // Access error, data arriving on the last watchdog cycle.
    pc_step(32'h8000_0008);
    do_fetch(32'h8000_0008, 0, 3, 32'hDEAD_BEEF, 2'b10, 1, "err");
    check("err_ar_count", 128'(ar_count), 128'(3));

    // Watchdog expiry with no response; late data must be ignored.
    pc_step(32'h8000_0020);
    e = '{inst: 32'h0, pc: 32'h8000_0020, fault: 1'b1, cause: 2'b11};
    sb.push_back(e);
    wait_for(0, "to_ar");
    check("to_araddr", 128'(araddr), 128'(32'h8000_0020));
    arready = 1'b1;
    wait_for(1, "to_r");
    arready = 1'b0;
    n_resp = 0;
    while (rready && n_resp < 20) begin
      n_resp++;
      @(negedge clk);
    end
    check("to_resp_cycles", 128'(n_resp), 128'(4));
    check("to_out", 128'({inst_valid, rready}), 128'({1'b1, 1'b0}));
    rvalid = 1'b1;
    rdata  = 32'h1234_5678;
    repeat (2) begin
      @(negedge clk);
      check("to_late_ignored", 128'({inst_valid, inst}), 128'({1'b1, 32'h0}));
    end
    inst_ready = 1'b1;
    out_check("to");
    @(negedge clk);
    rvalid     = 1'b0;
    rdata      = 32'h0;
    inst_ready = 1'b0;
    check("to_idle", 128'({inst_valid, busy, 32'(ar_count)}), 128'({1'b0, 1'b0, 32'd4}));

    // pc update during RESP is fetched after the current transaction.
    pc_step(32'h8000_0030);
    e = '{inst: 32'h0000_A0B7, pc: 32'h8000_0030, fault: 1'b0, cause: 2'b00};
    sb.push_back(e);
    wait_for(0, "upd_ar");
    check("upd_araddr", 128'(araddr), 128'(32'h8000_0030));
    arready = 1'b1;
    wait_for(1, "upd_r");
    arready = 1'b0;
    pc_step(32'h8000_0010);
    @(negedge clk);
    rvalid = 1'b1;
    rdata  = 32'h0000_A0B7;
    wait_for(2, "upd_out");
    rvalid     = 1'b0;
    inst_ready = 1'b1;
    out_check("upd");
    @(negedge clk);
    inst_ready = 1'b0;
    check("upd_drop", 128'(inst_valid), 128'(1'b0));
    wait_for(0, "upd_ar2");
    check("upd_araddr2", 128'(araddr), 128'(32'h8000_0010));

    // Reset while in REQ: request drops at once, pending survives.
    rst = 1'b0;
    #1;
    check("rst_req", 128'({arvalid, rready, inst_valid, busy, araddr}),
          128'({1'b0, 1'b0, 1'b0, 1'b1, 32'h0}));
    @(negedge clk);
    rst = 1'b1;
    do_fetch(32'h8000_0010, 0, 0, 32'h0041_0113, 2'b00, 0, "post_rst");
    check("final_ar_count", 128'(ar_count), 128'(6));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
